dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/riscv_pkg.sv | 60 ++++++
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 173 +++++++++++++++++
 tb/tb_dmem_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store funct3 encodings, data-memory FSM
// states and access-size decode helpers used by the data-memory responder.
package riscv_pkg;

   // Load/store funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } access_size_t;

   // Access size for a funct3; any encoding that is not a defined byte/half
   // access for this direction is treated as a full word.
   function automatic access_size_t accessSize(input logic [2:0] funct3, input logic isStore);
      access_size_t size;
      size = SZ_WORD;
      if (isStore) begin
         case (funct3)
            F3_SB:   size = SZ_BYTE;
            F3_SH:   size = SZ_HALF;
            default: size = SZ_WORD;
         endcase
      end else begin
         case (funct3)
            F3_LB, F3_LBU: size = SZ_BYTE;
            F3_LH, F3_LHU: size = SZ_HALF;
            default:       size = SZ_WORD;
         endcase
      end
      return size;
   endfunction

   // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
   function automatic logic isMisaligned(input access_size_t size, input logic [1:0] lowAddr);
      logic mis;
      mis = 1'b0;
      case (size)
         SZ_HALF: mis = lowAddr[0];
         SZ_WORD: mis = |lowAddr;
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 data memory with per-byte write enables and a
// registered (read-first) read port.
module dmem_array #(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [3:0]               byteEn,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   // Byte-lane writes and synchronous read of the addressed word
   // NOTE: no reset branch here on purpose -- storage arrays are never reset,
   // which keeps them mappable onto block RAM; sequential state uses <= so
   // every register samples the pre-edge values.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (byteEn[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the memory pipeline stage. Accepts a
// load/store in IDLE, stalls the pipeline for LATENCY cycles, then performs
// the store or presents extended load data in DONE.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned-access trap).
module dmem_responder
   import riscv_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_readM,
   input  logic        mem_writeM,
   input  logic [2:0]  funct3M,
   input  logic [31:0] addrM,
   input  logic [31:0] wdataM,
   output logic [31:0] rdataM,
   output logic        stallM,
   output logic        misalignM
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   dmem_state_t   state, stateNext;
   logic [CW-1:0] cnt, cntNext;
   logic          accept;

   logic [AW+1:0] capAddr;
   logic [31:0]   capWdata;
   logic [2:0]    capFunct3;
   logic          capStore;

   access_size_t  size;
   logic          misalignHit;
   logic [AW-1:0] arrIdx;
   logic [3:0]    byteEn;
   logic [31:0]   arrWdata;
   logic [31:0]   arrRdata;
   logic [31:0]   loadData;
   logic [31:0]   rdataHold;
   logic          loadDone;

   // Address bits above the memory size wrap around and are not used.
   logic unusedAddrBits;
   assign unusedAddrBits = ^addrM[31:AW+2];

   // Next-state, counter and stall decode
   // NOTE: every output of this block gets a default before the case, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      stallM    = 1'b0;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_readM || mem_writeM) begin
               stallM    = 1'b1;
               accept    = 1'b1;
               cntNext   = CW'(LATENCY - 1);
               stateNext = (LATENCY > 1) ? WAIT : DONE;
            end
         end
         WAIT: begin
            stallM  = 1'b1;
            cntNext = cnt - CW'(1);
            if (cntNext == '0) stateNext = DONE;
         end
         DONE:    stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      if (rst) stallM = 1'b0;
   end

   // State and latency counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Capture the request once; it stays frozen for the whole transaction
   always_ff @(posedge clk) begin
      if (rst) begin
         capAddr   <= '0;
         capWdata  <= '0;
         capFunct3 <= '0;
         capStore  <= 1'b0;
      end else if (accept) begin
         capAddr   <= addrM[AW+1:0];
         capWdata  <= wdataM;
         capFunct3 <= funct3M;
         capStore  <= mem_writeM;
      end
   end

   assign size = accessSize(capFunct3, capStore);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalignHit = isMisaligned(size, capAddr[1:0]);
`else
   assign misalignHit = 1'b0;
`endif

   assign misalignM = (state == DONE) && misalignHit;

   // In IDLE the array reads the incoming address so the word is ready when
   // DONE arrives even with LATENCY=1; afterwards the captured address drives it.
   assign arrIdx = (state == IDLE) ? addrM[AW+1:2] : capAddr[AW+1:2];

   // Store lane enables and lane-replicated write data
   always_comb begin
      byteEn   = 4'b0000;
      arrWdata = capWdata;
      case (size)
         SZ_BYTE: begin
            byteEn   = 4'b0001 << capAddr[1:0];
            arrWdata = {4{capWdata[7:0]}};
         end
         SZ_HALF: begin
            byteEn   = capAddr[1] ? 4'b1100 : 4'b0011;
            arrWdata = {2{capWdata[15:0]}};
         end
         default: begin
            byteEn   = 4'b1111;
            arrWdata = capWdata;
         end
      endcase
      if (state != DONE || !capStore || misalignHit || rst) byteEn = 4'b0000;
   end

   dmem_array #(.DEPTH(DEPTH)) uArray (
      .clk    (clk),
      .addr   (arrIdx),
      .byteEn (byteEn),
      .wdata  (arrWdata),
      .rdata  (arrRdata)
   );

   // Lane selection and sign/zero extension of load data
   always_comb begin
      logic [31:0] shifted;
      logic [15:0] half;
      shifted  = arrRdata >> {capAddr[1:0], 3'b000};
      half     = capAddr[1] ? arrRdata[31:16] : arrRdata[15:0];
      loadData = arrRdata;
      case (size)
         SZ_BYTE: loadData = capFunct3[2] ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: loadData = capFunct3[2] ? {16'b0, half}
                                          : {{16{half[15]}}, half};
         default: loadData = arrRdata;
      endcase
      if (misalignHit) loadData = '0;
   end

   assign loadDone = (state == DONE) && !capStore;

   // Hold the last load result until the next load completes
   always_ff @(posedge clk) begin
      if (rst)           rdataHold <= '0;
      else if (loadDone) rdataHold <= loadData;
   end

   assign rdataM = loadDone ? loadData : rdataHold;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by
// randomized traffic compared against a byte-level memory model.
module tb_dmem_responder;

   localparam int DEPTH   = 1024;
   localparam int LATENCY = 2;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_readM;
   logic        mem_writeM;
   logic [2:0]  funct3M;
   logic [31:0] addrM;
   logic [31:0] wdataM;
   logic [31:0] rdataM;
   logic        stallM;
   logic        misalignM;

   int checks   = 0;
   int failures = 0;

   logic [31:0] model [int];
   logic [31:0] lastLoad;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_readM  (mem_readM),
      .mem_writeM (mem_writeM),
      .funct3M    (funct3M),
      .addrM      (addrM),
      .wdataM     (wdataM),
      .rdataM     (rdataM),
      .stallM     (stallM),
      .misalignM  (misalignM)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Access width in bytes for a request
   function automatic int sizeOf(input bit isStore, input logic [2:0] f3);
      if (isStore) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic bit misaligned(input int sz, input logic [31:0] a);
      return TRAP && ((sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00));
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) & 32'(DEPTH - 1));
   endfunction

   // Reference model: apply one access, return expected rdata and trap flag
   task automatic modelAccess(input bit rd, input bit wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              output logic [31:0] expRdata, output logic expMis);
      bit          isStore;
      int          sz;
      int          off;
      int          idx;
      logic [31:0] word;
      logic [31:0] raw;
      logic [31:0] val;
      isStore = wr;
      sz      = sizeOf(isStore, f3);
      expMis  = misaligned(sz, a);
      idx     = widx(a);
      word    = model.exists(idx) ? model[idx] : 32'h0;
      off     = (sz == 1) ? int'(a[1:0]) : (sz == 2) ? 2 * int'(a[1]) : 0;
      if (isStore) begin
         if (!expMis) begin
            for (int b = 0; b < sz; b++) word[8*(off+b) +: 8] = wd[8*b +: 8];
            model[idx] = word;
         end
         expRdata = lastLoad;
      end else begin
         if (expMis) begin
            val = 32'h0;
         end else begin
            raw = word >> (8 * off);
            if (sz == 1) begin
               val = {24'h0, raw[7:0]};
               if (!f3[2] && raw[7]) val[31:8] = '1;
            end else if (sz == 2) begin
               val = {16'h0, raw[15:0]};
               if (!f3[2] && raw[15]) val[31:16] = '1;
            end else begin
               val = word;
            end
         end
         lastLoad = val;
         expRdata = val;
      end
      if (!rd && !wr) expRdata = lastLoad;
   endtask

   // One bus transaction; called #1 after a rising edge
   task automatic access(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
      logic [31:0] expRdata;
      logic        expMis;
      int          stalls;
      logic        misDuring;
      bit          done;
      modelAccess(rd, wr, f3, a, wd, expRdata, expMis);
      mem_readM  = rd;
      mem_writeM = wr;
      funct3M    = f3;
      addrM      = a;
      wdataM     = wd;
      stalls     = 0;
      misDuring  = 1'b0;
      done       = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (stallM) begin
            stalls++;
            misDuring = misDuring | misalignM;
            // Captured fields must ignore input changes once accepted
            if (stalls >= 2) begin
               addrM   = $urandom;
               wdataM  = $urandom;
               funct3M = 3'($urandom_range(0, 7));
            end
         end else begin
            done = 1'b1;
         end
      end
      check({tag, " done-reached"}, 32'(done), 32'd1);
      if (done) begin
         check({tag, " stall-cycles"}, 32'(stalls), 32'(LATENCY));
         check({tag, " misalign-in-stall"}, 32'(misDuring), 32'd0);
         check({tag, " misalign"}, 32'(misalignM), 32'(expMis));
         check({tag, " rdata"}, rdataM, expRdata);
      end
      @(posedge clk);
      #1;
      if (!hold) begin
         mem_readM  = 1'b0;
         mem_writeM = 1'b0;
      end
   endtask

   // Idle one cycle and confirm the held load value
   task automatic expectHeld(input string tag, input logic [31:0] val);
      @(negedge clk);
      check({tag, " held-rdata"}, rdataM, val);
      check({tag, " idle-no-stall"}, 32'(stallM), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [2:0]  f3;
      int          op;
      rst        = 1'b1;
      mem_readM  = 1'b0;
      mem_writeM = 1'b0;
      funct3M    = 3'd0;
      addrM      = 32'h0;
      wdataM     = 32'h0;
      lastLoad   = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset stallM", 32'(stallM), 32'd0);
      check("reset misalignM", 32'(misalignM), 32'd0);
      check("reset rdataM", rdataM, 32'h0);
      @(posedge clk);
      #1;

      // SW then LW at 0x10
      access("sw 0x10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
      access("lw 0x10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
      expectHeld("lw 0x10", 32'hDEADBEEF);

      // Sign/zero extension of byte and half loads
      access("sw 0x20", 1'b0, 1'b1, 3'b010, 32'h20, 32'h000080F0, 1'b0);
      access("lb 0x20", 1'b1, 1'b0, 3'b000, 32'h20, 32'h0, 1'b0);
      expectHeld("lb 0x20", 32'hFFFFFFF0);
      access("lbu 0x20", 1'b1, 1'b0, 3'b100, 32'h20, 32'h0, 1'b0);
      expectHeld("lbu 0x20", 32'h000000F0);
      access("lh 0x20", 1'b1, 1'b0, 3'b001, 32'h20, 32'h0, 1'b0);
      expectHeld("lh 0x20", 32'hFFFF80F0);
      access("lhu 0x20", 1'b1, 1'b0, 3'b101, 32'h20, 32'h0, 1'b0);
      expectHeld("lhu 0x20", 32'h000080F0);

      // Byte store into the top lane
      access("sw 0x20b", 1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0);
      access("sb 0x23", 1'b0, 1'b1, 3'b000, 32'h23, 32'h000000AA, 1'b0);
      expectHeld("sb keeps rdata", 32'h000080F0);
      access("lw 0x20b", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
      expectHeld("lw 0x20b", 32'hAA223344);

      // Back-to-back loads with the request held through DONE
      access("b2b lw1", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
      access("b2b lw2", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
      expectHeld("b2b", 32'hAA223344);

      // Misaligned word store
      access("sw 0x100", 1'b0, 1'b1, 3'b010, 32'h100, 32'h01020304, 1'b0);
      access("sw 0x102", 1'b0, 1'b1, 3'b010, 32'h102, 32'hCAFEF00D, 1'b0);
      access("lw 0x100", 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
      expectHeld("misaligned sw", TRAP ? 32'h01020304 : 32'hCAFEF00D);

      // Reset in the middle of a store
      access("sw 0x08", 1'b0, 1'b1, 3'b010, 32'h08, 32'h13579BDF, 1'b0);
      mem_writeM = 1'b1;
      funct3M    = 3'b010;
      addrM      = 32'h08;
      wdataM     = 32'h5555AAAA;
      @(negedge clk);
      check("rst-sw accept stall", 32'(stallM), 32'd1);
      @(posedge clk);
      #1;
      rst        = 1'b1;
      mem_writeM = 1'b0;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      lastLoad = 32'h0;
      @(negedge clk);
      check("after-rst stallM", 32'(stallM), 32'd0);
      check("after-rst misalignM", 32'(misalignM), 32'd0);
      check("after-rst rdataM", rdataM, 32'h0);
      @(posedge clk);
      #1;
      access("lw 0x08", 1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b0);
      expectHeld("rst abandoned sw", 32'h13579BDF);

      // Preload a 16-word window, then random traffic with address aliasing
      for (int i = 0; i < 16; i++) begin
         access("init", 1'b0, 1'b1, 3'b010, 32'(i * 4), $urandom, 1'b0);
      end
      for (int n = 0; n < 300; n++) begin
         a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
         f3 = 3'($urandom_range(0, 7));
         op = $urandom_range(0, 3);
         access($sformatf("rnd%0d", n), op != 2, op >= 2, f3, a, $urandom, 1'($urandom_range(0, 1)));
      end
      mem_readM  = 1'b0;
      mem_writeM = 1'b0;
      expectHeld("final", lastLoad);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
